// File: rtl/core_sequencer.sv
// Multi-cycle control sequencer: fetch/decode/execute/memory/writeback with
// a per-access memory timeout and sticky illegal/bus_fault flags.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | one cycle after reset release, outputs quiet
// FETCH     | instruction read from PC, ir_we on mem_ready
// DECODE    | latch opcode into op_q, check legality
// EXECUTE   | ALU operates on op_q; branches resolve here
// MEMORY    | load/store data access at ALU address
// WRITEBACK | register file write and PC update
// HALT      | absorbing until reset (illegal opcode or bus timeout)
module core_sequencer #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  instr_opcode,
    input  logic [31:0] alu_result,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_src,
    output logic        ir_we,
    output logic        pc_we,
    output logic        rf_we,
    output logic [1:0]  pc_src,
    output logic [1:0]  alu_a_sel,
    output logic        alu_b_sel,
    output logic [6:0]  alu_op,
    output logic [1:0]  rf_wd_sel,
    output logic        illegal,
    output logic        bus_fault,
    output logic [2:0]  state
);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_ALU    = 2'd1;
    localparam logic [1:0] PC_BRANCH = 2'd2;

    localparam logic [1:0] WD_ALU  = 2'd0;
    localparam logic [1:0] WD_LOAD = 2'd1;
    localparam logic [1:0] WD_LINK = 2'd2;
    localparam logic [1:0] WD_IMM  = 2'd3;

    localparam logic [7:0] TMO_LIMIT = 8'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEMORY    = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_HALT      = 3'd6
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [6:0]  op_q;
    logic [7:0]  tmo_cnt;
    logic        timeout_hit;
    logic [1:0]  sel_a;
    logic        sel_b;

    function automatic logic is_legal(input logic [6:0] op);
        case (op)
            OP_R, OP_I, OP_LOAD, OP_S, OP_B,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: is_legal = 1'b1;
            default:                           is_legal = 1'b0;
        endcase
    endfunction

    // Operand routing depends only on the latched opcode.
    always_comb begin
        sel_a = 2'd0;
        sel_b = 1'b0;
        case (op_q)
            OP_R, OP_B:                     begin sel_a = 2'd0; sel_b = 1'b0; end
            OP_I, OP_LOAD, OP_S, OP_JALR:   begin sel_a = 2'd0; sel_b = 1'b1; end
            OP_JAL, OP_AUIPC:               begin sel_a = 2'd1; sel_b = 1'b1; end
            OP_LUI:                         begin sel_a = 2'd2; sel_b = 1'b1; end
            default:                        begin sel_a = 2'd0; sel_b = 1'b0; end
        endcase
    end

    // A ready arriving in the limit cycle takes precedence over the timeout.
    assign timeout_hit = mem_req && !mem_ready && (tmo_cnt == TMO_LIMIT);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   state_d = ST_FETCH;
            ST_FETCH: begin
                if (mem_ready)        state_d = ST_DECODE;
                else if (timeout_hit) state_d = ST_HALT;
            end
            ST_DECODE: state_d = is_legal(instr_opcode) ? ST_EXECUTE : ST_HALT;
            ST_EXECUTE: begin
                case (op_q)
                    OP_LOAD, OP_S: state_d = ST_MEMORY;
                    OP_B:          state_d = ST_FETCH;
                    default:       state_d = ST_WRITEBACK;
                endcase
            end
            ST_MEMORY: begin
                if (mem_ready)        state_d = (op_q == OP_S) ? ST_FETCH : ST_WRITEBACK;
                else if (timeout_hit) state_d = ST_HALT;
            end
            ST_WRITEBACK: state_d = ST_FETCH;
            ST_HALT:      state_d = ST_HALT;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            op_q      <= 7'd0;
            tmo_cnt   <= 8'd0;
            illegal   <= 1'b0;
            bus_fault <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_DECODE) begin
                op_q <= instr_opcode;
                if (!is_legal(instr_opcode)) illegal <= 1'b1;
            end
            if (timeout_hit) bus_fault <= 1'b1;
            if (state_d != state_q)
                tmo_cnt <= 8'd0;
            else if (mem_req && !mem_ready)
                tmo_cnt <= tmo_cnt + 8'd1;
        end
    end

    // Moore decode of state/op_q; only ir_we and the PC strobes in
    // EXECUTE/MEMORY look at mem_ready or alu_result directly.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_src   = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        rf_we     = 1'b0;
        pc_src    = PC_PLUS4;
        alu_a_sel = 2'd0;
        alu_b_sel = 1'b0;
        alu_op    = 7'd0;
        rf_wd_sel = WD_ALU;
        if (state_q == ST_EXECUTE || state_q == ST_MEMORY || state_q == ST_WRITEBACK) begin
            alu_op    = op_q;
            alu_a_sel = sel_a;
            alu_b_sel = sel_b;
        end
        case (state_q)
            ST_FETCH: begin
                mem_req = 1'b1;
                ir_we   = mem_ready;
            end
            ST_EXECUTE: begin
                if (op_q == OP_B) begin
                    pc_we  = 1'b1;
                    pc_src = (|alu_result) ? PC_BRANCH : PC_PLUS4;
                end
            end
            ST_MEMORY: begin
                mem_req = 1'b1;
                mem_src = 1'b1;
                mem_we  = (op_q == OP_S);
                pc_we   = (op_q == OP_S) && mem_ready;
            end
            ST_WRITEBACK: begin
                rf_we = 1'b1;
                pc_we = 1'b1;
                case (op_q)
                    OP_LOAD:          rf_wd_sel = WD_LOAD;
                    OP_JAL, OP_JALR:  rf_wd_sel = WD_LINK;
                    OP_LUI:           rf_wd_sel = WD_IMM;
                    default:          rf_wd_sel = WD_ALU;
                endcase
                if (op_q == OP_JAL || op_q == OP_JALR) pc_src = PC_ALU;
            end
            default: ;
        endcase
    end

    assign state = state_q;

    mem_we_needs_req: assert property (@(posedge clk) disable iff (!rst_n) mem_we |-> mem_req);
    halt_absorbing:   assert property (@(posedge clk) disable iff (!rst_n)
                                       (state_q == ST_HALT) |=> (state_q == ST_HALT));

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: each task walks one instruction class or
// corner case and compares the full output word against hand-derived values.
module tb_core_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  instr_opcode = 7'd0;
    logic [31:0] alu_result = 32'd0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_we, mem_src, ir_we, pc_we, rf_we;
    logic [1:0]  pc_src, alu_a_sel, rf_wd_sel;
    logic        alu_b_sel, illegal, bus_fault;
    logic [6:0]  alu_op;
    logic [2:0]  state;

    int total = 0;
    int bad   = 0;
    logic [24:0] want;

    // Table for the single-writeback classes: I, JAL, JALR, LUI, AUIPC.
    localparam logic [6:0] T_OP [5] = '{7'h13, 7'h6F, 7'h67, 7'h37, 7'h17};
    localparam logic [1:0] T_A  [5] = '{2'd0,  2'd1,  2'd0,  2'd2,  2'd1};
    localparam logic       T_B  [5] = '{1'b1,  1'b1,  1'b1,  1'b1,  1'b1};
    localparam logic [1:0] T_WD [5] = '{2'd0,  2'd2,  2'd2,  2'd3,  2'd0};
    localparam logic [1:0] T_PS [5] = '{2'd0,  2'd1,  2'd1,  2'd0,  2'd0};

    core_sequencer #(.MEM_TIMEOUT(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr_opcode (instr_opcode),
        .alu_result   (alu_result),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_src      (mem_src),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .rf_we        (rf_we),
        .pc_src       (pc_src),
        .alu_a_sel    (alu_a_sel),
        .alu_b_sel    (alu_b_sel),
        .alu_op       (alu_op),
        .rf_wd_sel    (rf_wd_sel),
        .illegal      (illegal),
        .bus_fault    (bus_fault),
        .state        (state)
    );

    always #5 clk = ~clk;

    // Observed word: {state, mem_req, mem_we, mem_src, ir_we, pc_we, rf_we,
    //                 pc_src, alu_a_sel, alu_b_sel, alu_op, rf_wd_sel, illegal, bus_fault}
    wire [24:0] obs = {state, mem_req, mem_we, mem_src, ir_we, pc_we, rf_we,
                       pc_src, alu_a_sel, alu_b_sel, alu_op, rf_wd_sel, illegal, bus_fault};

    function automatic logic [24:0] ex(input logic [2:0] st, input logic [5:0] strobes,
                                       input logic [1:0] psrc, input logic [1:0] a,
                                       input logic b, input logic [6:0] op,
                                       input logic [1:0] wd, input logic ill, input logic bf);
        return {st, strobes, psrc, a, b, op, wd, ill, bf};
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #2;
        want = 25'd0;
        total++; if (obs !== want) begin bad++; $display("FAIL reset_hold got=%h want=%h", obs, want); end
        rst_n = 1'b1;
        #1;
        total++; if (obs !== want) begin bad++; $display("FAIL reset_idle got=%h want=%h", obs, want); end
        tick();
        want = ex(3'd1, 6'b100000, 2'd0, 2'd0, 1'b0, 7'h00, 2'd0, 1'b0, 1'b0);
        total++; if (obs !== want) begin bad++; $display("FAIL reset_to_fetch got=%h want=%h", obs, want); end
    endtask

    task automatic test_rtype();
        do_reset();
        mem_ready = 1'b1; instr_opcode = 7'h33; alu_result = 32'd5;
        #1;
        tick();
        want = ex(3'd1, 6'b100100, 2'd0, 2'd0, 1'b0, 7'h00, 2'd0, 1'b0, 1'b0);
        total++; if (obs !== want) begin bad++; $display("FAIL r_fetch got=%h want=%h", obs, want); end
        tick();
        want = ex(3'd2, 6'b000000, 2'd0, 2'd0, 1'b0, 7'h00, 2'd0, 1'b0, 1'b0);
        total++; if (obs !== want) begin bad++; $display("FAIL r_decode got=%h want=%h", obs, want); end
        tick();
        want = ex(3'd3, 6'b000000, 2'd0, 2'd0, 1'b0, 7'h33, 2'd0, 1'b0, 1'b0);
        total++; if (obs !== want) begin bad++; $display("FAIL r_execute got=%h want=%h", obs, want); end
        tick();
        want = ex(3'd5, 6'b000011, 2'd0, 2'd0, 1'b0, 7'h33, 2'd0, 1'b0, 1'b0);
        total++; if (obs !== want) begin bad++; $display("FAIL r_writeback got=%h want=%h", obs, want); end
        tick();
        want = ex(3'd1, 6'b100100, 2'd0, 2'd0, 1'b0, 7'h00, 2'd0, 1'b0, 1'b0);
        total++; if (obs !== want) begin bad++; $display("FAIL r_refetch got=%h want=%h", obs, want); end
    endtask

    task automatic test_branch();
        do_reset();
        mem_ready = 1'b1; instr_opcode = 7'h63; alu_result = 32'hFFFF_FFFF;
        #1;
        tick(); tick(); tick();
        want = ex(3'd3, 6'b000010, 2'd2, 2'd0, 1'b0, 7'h63, 2'd0, 1'b0, 1'b0);
        total++; if (obs !== want) begin bad++; $display("FAIL b_taken_exec got=%h want=%h", obs, want); end
        tick();
        want = ex(3'd1, 6'b100100, 2'd0, 2'd0, 1'b0, 7'h00, 2'd0, 1'b0, 1'b0);
        total++; if (obs !== want) begin bad++; $display("FAIL b_taken_fetch got=%h want=%h", obs, want); end
        alu_result = 32'd0;
        #1;
        tick(); tick();
        want = ex(3'd3, 6'b000010, 2'd0, 2'd0, 1'b0, 7'h63, 2'd0, 1'b0, 1'b0);
        total++; if (obs !== want) begin bad++; $display("FAIL b_not_taken_exec got=%h want=%h", obs, want); end
        tick();
        want = ex(3'd1, 6'b100100, 2'd0, 2'd0, 1'b0, 7'h00, 2'd0, 1'b0, 1'b0);
        total++; if (obs !== want) begin bad++; $display("FAIL b_not_taken_fetch got=%h want=%h", obs, want); end
    endtask

    task automatic test_load();
        do_reset();
        mem_ready = 1'b1; instr_opcode = 7'h03; alu_result = 32'h100;
        #1;
        tick(); tick(); tick();
        want = ex(3'd3, 6'b000000, 2'd0, 2'd0, 1'b1, 7'h03, 2'd0, 1'b0, 1'b0);
        total++; if (obs !== want) begin bad++; $display("FAIL ld_execute got=%h want=%h", obs, want); end
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            want = ex(3'd4, 6'b101000, 2'd0, 2'd0, 1'b1, 7'h03, 2'd0, 1'b0, 1'b0);
            total++; if (obs !== want) begin bad++; $display("FAIL ld_mem_wait%0d got=%h want=%h", i, obs, want); end
        end
        tick();
        mem_ready = 1'b1;
        #1;
        total++; if (obs !== want) begin bad++; $display("FAIL ld_mem_ready got=%h want=%h", obs, want); end
        tick();
        want = ex(3'd5, 6'b000011, 2'd0, 2'd0, 1'b1, 7'h03, 2'd1, 1'b0, 1'b0);
        total++; if (obs !== want) begin bad++; $display("FAIL ld_writeback got=%h want=%h", obs, want); end
        tick();
        want = ex(3'd1, 6'b100100, 2'd0, 2'd0, 1'b0, 7'h00, 2'd0, 1'b0, 1'b0);
        total++; if (obs !== want) begin bad++; $display("FAIL ld_refetch got=%h want=%h", obs, want); end
    endtask

    task automatic test_store();
        do_reset();
        mem_ready = 1'b1; instr_opcode = 7'h23;
        #1;
        tick(); tick(); tick();
        want = ex(3'd3, 6'b000000, 2'd0, 2'd0, 1'b1, 7'h23, 2'd0, 1'b0, 1'b0);
        total++; if (obs !== want) begin bad++; $display("FAIL st_execute got=%h want=%h", obs, want); end
        tick();
        want = ex(3'd4, 6'b111010, 2'd0, 2'd0, 1'b1, 7'h23, 2'd0, 1'b0, 1'b0);
        total++; if (obs !== want) begin bad++; $display("FAIL st_memory got=%h want=%h", obs, want); end
        tick();
        want = ex(3'd1, 6'b100100, 2'd0, 2'd0, 1'b0, 7'h00, 2'd0, 1'b0, 1'b0);
        total++; if (obs !== want) begin bad++; $display("FAIL st_refetch got=%h want=%h", obs, want); end
    endtask

    task automatic test_other_types();
        do_reset();
        mem_ready = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            instr_opcode = T_OP[i];
            #1;
            tick(); tick();
            want = ex(3'd3, 6'b000000, 2'd0, T_A[i], T_B[i], T_OP[i], 2'd0, 1'b0, 1'b0);
            total++; if (obs !== want) begin bad++; $display("FAIL op%h_execute got=%h want=%h", T_OP[i], obs, want); end
            tick();
            want = ex(3'd5, 6'b000011, T_PS[i], T_A[i], T_B[i], T_OP[i], T_WD[i], 1'b0, 1'b0);
            total++; if (obs !== want) begin bad++; $display("FAIL op%h_writeback got=%h want=%h", T_OP[i], obs, want); end
            tick();
            want = ex(3'd1, 6'b100100, 2'd0, 2'd0, 1'b0, 7'h00, 2'd0, 1'b0, 1'b0);
            total++; if (obs !== want) begin bad++; $display("FAIL op%h_refetch got=%h want=%h", T_OP[i], obs, want); end
        end
    endtask

    task automatic test_illegal();
        do_reset();
        mem_ready = 1'b1; instr_opcode = 7'h7F;
        #1;
        tick(); tick(); tick();
        want = ex(3'd6, 6'b000000, 2'd0, 2'd0, 1'b0, 7'h00, 2'd0, 1'b1, 1'b0);
        total++; if (obs !== want) begin bad++; $display("FAIL illegal_halt got=%h want=%h", obs, want); end
        instr_opcode = 7'h33;
        repeat (3) tick();
        total++; if (obs !== want) begin bad++; $display("FAIL illegal_absorb got=%h want=%h", obs, want); end
        do_reset();
        want = 25'd0;
        total++; if (obs !== want) begin bad++; $display("FAIL illegal_cleared got=%h want=%h", obs, want); end
    endtask

    task automatic test_timeout();
        do_reset();
        mem_ready = 1'b0; instr_opcode = 7'h33;
        #1;
        tick();
        for (int c = 1; c <= 16; c++) begin
            want = ex(3'd1, 6'b100000, 2'd0, 2'd0, 1'b0, 7'h00, 2'd0, 1'b0, 1'b0);
            total++; if (obs !== want) begin bad++; $display("FAIL fetch_wait%0d got=%h want=%h", c, obs, want); end
            tick();
        end
        want = ex(3'd6, 6'b000000, 2'd0, 2'd0, 1'b0, 7'h00, 2'd0, 1'b0, 1'b1);
        total++; if (obs !== want) begin bad++; $display("FAIL fetch_timeout got=%h want=%h", obs, want); end
        mem_ready = 1'b1;
        tick();
        total++; if (obs !== want) begin bad++; $display("FAIL timeout_absorb got=%h want=%h", obs, want); end
    endtask

    task automatic test_ready_at_limit();
        do_reset();
        mem_ready = 1'b0; instr_opcode = 7'h33;
        #1;
        tick();
        repeat (15) tick();
        mem_ready = 1'b1;
        #1;
        want = ex(3'd1, 6'b100100, 2'd0, 2'd0, 1'b0, 7'h00, 2'd0, 1'b0, 1'b0);
        total++; if (obs !== want) begin bad++; $display("FAIL limit_ready_fetch got=%h want=%h", obs, want); end
        tick();
        want = ex(3'd2, 6'b000000, 2'd0, 2'd0, 1'b0, 7'h00, 2'd0, 1'b0, 1'b0);
        total++; if (obs !== want) begin bad++; $display("FAIL limit_ready_decode got=%h want=%h", obs, want); end
    endtask

    task automatic test_counter_clear();
        do_reset();
        mem_ready = 1'b0; instr_opcode = 7'h03;
        #1;
        tick();
        repeat (10) tick();
        mem_ready = 1'b1;
        #1;
        tick(); tick();
        mem_ready = 1'b0;
        #1;
        tick();
        repeat (14) tick();
        want = ex(3'd4, 6'b101000, 2'd0, 2'd0, 1'b1, 7'h03, 2'd0, 1'b0, 1'b0);
        total++; if (obs !== want) begin bad++; $display("FAIL clr_mem_wait15 got=%h want=%h", obs, want); end
        tick();
        total++; if (obs !== want) begin bad++; $display("FAIL clr_mem_wait16 got=%h want=%h", obs, want); end
        tick();
        want = ex(3'd6, 6'b000000, 2'd0, 2'd0, 1'b0, 7'h00, 2'd0, 1'b0, 1'b1);
        total++; if (obs !== want) begin bad++; $display("FAIL clr_mem_timeout got=%h want=%h", obs, want); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        mem_ready = 1'b1; instr_opcode = 7'h03;
        #1;
        tick(); tick(); tick();
        mem_ready = 1'b0;
        tick();
        want = ex(3'd4, 6'b101000, 2'd0, 2'd0, 1'b1, 7'h03, 2'd0, 1'b0, 1'b0);
        total++; if (obs !== want) begin bad++; $display("FAIL mid_memory got=%h want=%h", obs, want); end
        rst_n = 1'b0;
        #1;
        want = 25'd0;
        total++; if (obs !== want) begin bad++; $display("FAIL mid_reset_drop got=%h want=%h", obs, want); end
        tick();
        total++; if (obs !== want) begin bad++; $display("FAIL mid_reset_hold got=%h want=%h", obs, want); end
        rst_n = 1'b1;
        #1;
        total++; if (obs !== want) begin bad++; $display("FAIL mid_release_idle got=%h want=%h", obs, want); end
        tick();
        want = ex(3'd1, 6'b100000, 2'd0, 2'd0, 1'b0, 7'h00, 2'd0, 1'b0, 1'b0);
        total++; if (obs !== want) begin bad++; $display("FAIL mid_release_fetch got=%h want=%h", obs, want); end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_branch();
        test_load();
        test_store();
        test_other_types();
        test_illegal();
        test_timeout();
        test_ready_at_limit();
        test_counter_clear();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/core_sequencer.md
CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16: maximum wait cycles for mem_ready per memory access (legal range 2..255).
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-004 SHALL have port instr_opcode, input, 7: opcode field of the instruction register; sampled only in DECODE.
REQ-005 SHALL have port alu_result, input, 32: ALU output; any nonzero value means branch taken.
REQ-006 SHALL have port mem_ready, input, 1: memory access complete; ignored while mem_req=0.
REQ-007 SHALL have these memory outputs: mem_req (1), mem_we (1), mem_src (1; 0=PC, 1=ALU address).
REQ-008 SHALL have these write strobes: ir_we (1), pc_we (1), rf_we (1).
REQ-009 SHALL have port pc_src, output, 2: 0=PC+4, 1=ALU result (jump target), 2=PC+imm (branch target).
REQ-010 SHALL have port alu_a_sel, output, 2: 0=rs1, 1=PC, 2=zero.
REQ-011 SHALL have port alu_b_sel, output, 1: 0=rs2, 1=immediate.
REQ-012 SHALL have port alu_op, output, 7: opcode forwarded to the ALU op_code input.
REQ-013 SHALL have port rf_wd_sel, output, 2: 0=ALU, 1=load data, 2=PC+4, 3=immediate.
REQ-014 SHALL have these status outputs: illegal (1, sticky), bus_fault (1, sticky), state (3, debug encoding).

Function
REQ-015 SHALL implement states IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, HALT=6; all outputs are a Moore decode of state plus latched opcode op_q, except the REQ-021/022 strobes.
REQ-016 SHALL transition IDLE->FETCH unconditionally on the first clock edge after reset release.
REQ-017 FETCH SHALL drive mem_req=1, mem_src=0, mem_we=0; on mem_ready it pulses ir_we=1 that cycle and moves to DECODE; otherwise it stays in FETCH.
REQ-018 DECODE (one cycle) SHALL latch op_q<=instr_opcode; legal opcodes (0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111) go to EXECUTE; any other value goes to HALT with illegal<=1.
REQ-019 In EXECUTE, MEMORY and WRITEBACK, alu_op SHALL equal op_q; in all other states alu_op=0.
REQ-020 Operand selects from op_q SHALL be:
- R/B: a=0, b=0
- I/LOAD/S/JALR: a=0, b=1
- JAL/AUIPC: a=1, b=1
- LUI: a=2, b=1
REQ-021 EXECUTE next state SHALL be:
- LOAD/S: MEMORY
- B: FETCH, with pc_we=1 and pc_src=2 if alu_result!=0, else pc_src=0
- all other opcodes: WRITEBACK
REQ-022 MEMORY SHALL drive mem_req=1, mem_src=1, mem_we=(op_q==S); on mem_ready, S goes to FETCH with pc_we=1, pc_src=0, and LOAD goes to WRITEBACK.
REQ-023 WRITEBACK (one cycle) SHALL drive:
- rf_we=1
- rf_wd_sel: LOAD=1, JAL/JALR=2, LUI=3, otherwise 0
- pc_we=1, with pc_src=1 for JAL/JALR, otherwise 0
- next state FETCH
REQ-024 Timeout counter SHALL:
- increment each cycle mem_req=1 and mem_ready=0
- clear on any state change
- when the count equals MEM_TIMEOUT-1 with mem_ready=0, go to HALT and set bus_fault<=1
- let mem_ready win if it arrives in the limit cycle
REQ-025 HALT SHALL be absorbing until reset, with all strobes, mem_req and mem_we at 0.
REQ-026 Every strobe (ir_we, pc_we, rf_we, mem_we) SHALL be active at most one cycle per state visit; mem_we is only high with mem_req.
REQ-027 Instruction latency SHALL be:
- B: 3 cycles plus fetch wait
- S: 4 cycles plus waits
- LOAD: 5 cycles plus waits
- R/I/JAL/JALR/LUI/AUIPC: 4 cycles plus waits

Reset
REQ-028 While rst_n=0, the block SHALL hold state=IDLE, op_q=0, counter=0, illegal=0, bus_fault=0, and drive all outputs 0.
REQ-029 An rst_n assertion at any time, including mid-access, SHALL immediately force the REQ-028 values, drop mem_req, and abandon the access.

Verification
REQ-030 Reset release, mem_ready=1, opcode 0110011, alu_result=5 -> state 0,1,2,3,5,1; ir_we in FETCH; rf_we=1, rf_wd_sel=0, pc_we=1, pc_src=0 in WRITEBACK.
REQ-031 Opcode 1100011, alu_result=FFFFFFFF -> EXECUTE gives pc_we=1, pc_src=2, then FETCH; with alu_result=0 -> pc_src=0.
REQ-032 Opcode 0000011, mem_ready low for 3 MEMORY cycles -> mem_src=1, mem_we=0 held; WRITEBACK gives rf_wd_sel=1.
REQ-033 Opcode 0100011 -> MEMORY gives mem_we=1; on mem_ready, pc_we=1 and return to FETCH; rf_we never set.
REQ-034 Opcode 1111111 -> illegal=1, state=6, outputs quiet; mem_ready never asserted in FETCH with MEM_TIMEOUT=16 -> bus_fault=1 after 16 FETCH cycles.
REQ-035 rst_n pulsed low during MEMORY -> mem_req=0 immediately; after release the sequence is IDLE then FETCH, with flags cleared.
